// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller in front of the combinational ALU.
// Holds one result slot and runs an iterative restoring divider.
module alu_exec_ctrl #(
  parameter int N    = 20,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic [N-1:0]    in_a,
  input  logic [N-1:0]    in_b,
  input  logic [TAGW-1:0] in_rd,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic [3:0]      alu_opcode,
  input  logic [N-1:0]    alu_result,
  input  logic            alu_z,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_result,
  output logic            out_z,
  output logic            out_divz,
  output logic [TAGW-1:0] out_rd,
  output logic            busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DIV
  } state_t;

  state_t          state;
  logic [TAGW-1:0] rd_q;
  logic [N:0]      rem;
  logic [N-1:0]    quo;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic [N+1:0]    sh;
  logic            ge;
  logic [N-1:0]    quo_nx;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  // One restoring-division step: shift in the next dividend bit, try subtract.
  always_comb begin
    sh     = {rem, quo[N-1]};
    ge     = (sh >= {2'b00, alu_b});
    quo_nx = {quo[N-2:0], ge};
  end

  // Control FSM, operand latches, divider datapath and the result slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rd_q       <= '0;
      rem        <= '0;
      quo        <= '0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_z      <= 1'b0;
      out_divz   <= 1'b0;
      out_rd     <= '0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            alu_a      <= in_a;
            alu_b      <= in_b;
            alu_opcode <= in_op;
            rd_q       <= in_rd;
            rem        <= '0;
            quo        <= in_a;
            cnt        <= '0;
            state      <= (in_op == OP_DIV) ? DIV : EXEC;
          end
        end
        EXEC: begin
          out_result <= alu_result;
          out_z      <= alu_z;
          out_divz   <= 1'b0;
          out_rd     <= rd_q;
          out_valid  <= 1'b1;
          state      <= IDLE;
        end
        DIV: begin
          if (alu_b == '0) begin
            out_result <= '1;
            out_z      <= 1'b0;
            out_divz   <= 1'b1;
            out_rd     <= rd_q;
            out_valid  <= 1'b1;
            state      <= IDLE;
          end else begin
            rem <= (N+1)'(ge ? sh - {2'b00, alu_b} : sh);
            quo <= quo_nx;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
              out_result <= quo_nx;
              out_z      <= (quo_nx == '0);
              out_divz   <= 1'b0;
              out_rd     <= rd_q;
              out_valid  <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a behavioural ALU
// and a queue of expected results.
module tb_alu_exec_ctrl;

  localparam int N    = 20;
  localparam int TAGW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      in_op = '0;
  logic [N-1:0]    in_a = '0;
  logic [N-1:0]    in_b = '0;
  logic [TAGW-1:0] in_rd = '0;
  logic [N-1:0]    alu_a;
  logic [N-1:0]    alu_b;
  logic [3:0]      alu_opcode;
  logic [N-1:0]    alu_result;
  logic            alu_z;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [N-1:0]    out_result;
  logic            out_z;
  logic            out_divz;
  logic [TAGW-1:0] out_rd;
  logic            busy;

  typedef struct {
    logic [N-1:0]    res;
    logic            z;
    logic            divz;
    logic [TAGW-1:0] rd;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_exec_ctrl #(.N(N), .TAGW(TAGW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_z      (alu_z),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_z      (out_z),
    .out_divz   (out_divz),
    .out_rd     (out_rd),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: ADD, SUB, CMP (less-than), XOR for 1010.
  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      4'b0000: alu_result = alu_a + alu_b;
      4'b0001: alu_result = alu_a - alu_b;
      4'b1000: alu_result = (alu_a < alu_b) ? N'(1) : N'(0);
      4'b1010: alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
    alu_z = (alu_result == '0);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] r, input logic z,
                      input logic dz, input logic [TAGW-1:0] rd);
    exp_t e;
    e.res = r; e.z = z; e.divz = dz; e.rd = rd;
    sb.push_back(e);
  endtask

  task automatic send(input logic [3:0] op, input logic [N-1:0] a,
                      input logic [N-1:0] b, input logic [TAGW-1:0] rd);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_op = 4'hF; in_a = '1; in_b = '0; in_rd = '1;
  endtask

  task automatic check_slot(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_result"}, 32'(out_result), 32'(e.res));
      chk({tag, "_z"}, 32'(out_z), 32'(e.z));
      chk({tag, "_divz"}, 32'(out_divz), 32'(e.divz));
      chk({tag, "_rd"}, 32'(out_rd), 32'(e.rd));
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int lat, input bit watch);
    int k = 0;
    while (k < 60) begin
      @(posedge clk);
      #1;
      k++;
      if (out_valid) break;
      if (watch) begin
        chk({tag, "_busy"}, 32'(busy), 1);
        chk({tag, "_inready"}, 32'(in_ready), 0);
      end
    end
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_latency"}, 32'(k), 32'(lat));
    check_slot(tag);
    consume();
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_result", 32'(out_result), 0);
    chk("rst_out_rd", 32'(out_rd), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_opcode", 32'(alu_opcode), 0);
    chk("rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    send(4'b0000, 20'd5, 20'd7, 4'd1);
    push(20'd12, 1'b0, 1'b0, 4'd1);
    chk("alu_a_latched", 32'(alu_a), 5);
    chk("alu_op_latched", 32'(alu_opcode), 0);
    wait_out("add", 1, 1'b0);

    send(4'b0001, 20'd9, 20'd9, 4'd2);
    push(20'd0, 1'b1, 1'b0, 4'd2);
    wait_out("sub", 1, 1'b0);

    send(4'b1000, 20'd3, 20'd8, 4'd3);
    push(20'h00001, 1'b0, 1'b0, 4'd3);
    wait_out("cmp", 1, 1'b0);

    send(4'b1010, 20'hAAAAA, 20'h55555, 4'd4);
    push(20'hFFFFF, 1'b0, 1'b0, 4'd4);
    wait_out("xor", 1, 1'b0);

    send(4'b0011, 20'd100, 20'd7, 4'd5);
    push(20'd14, 1'b0, 1'b0, 4'd5);
    wait_out("div", 20, 1'b1);

    send(4'b0011, 20'd5, 20'd9, 4'd6);
    push(20'd0, 1'b1, 1'b0, 4'd6);
    wait_out("div_small", 20, 1'b1);

    send(4'b0011, 20'hFFFFF, 20'd1, 4'd7);
    push(20'hFFFFF, 1'b0, 1'b0, 4'd7);
    wait_out("div_max", 20, 1'b1);

    send(4'b0011, 20'd123, 20'd0, 4'd8);
    push(20'hFFFFF, 1'b0, 1'b1, 4'd8);
    wait_out("div0", 1, 1'b0);

    // Backpressure: slot holds while a second op waits.
    send(4'b0000, 20'd2, 20'd3, 4'd9);
    push(20'd5, 1'b0, 1'b0, 4'd9);
    @(posedge clk);
    #1;
    chk("bp_first_valid", 32'(out_valid), 1);
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'b0001;
    in_a = 20'd10; in_b = 20'd4; in_rd = 4'd10;
    push(20'd6, 1'b0, 1'b0, 4'd10);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_valid_hold", 32'(out_valid), 1);
      chk("bp_result_hold", 32'(out_result), 5);
      chk("bp_busy", 32'(busy), 0);
    end
    check_slot("bp_first");
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_raise", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("bp_slot_cleared", 32'(out_valid), 0);
    chk("bp_second_busy", 32'(busy), 1);
    @(posedge clk);
    #1;
    chk("bp_second_valid", 32'(out_valid), 1);
    check_slot("bp_second");
    consume();

    // Reset in the middle of a divide aborts it.
    send(4'b0011, 20'd1000, 20'd3, 4'd11);
    repeat (10) @(posedge clk);
    #2;
    chk("mid_div_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_alu_a", 32'(alu_a), 0);
    chk("arst_alu_b", 32'(alu_b), 0);
    chk("arst_alu_opcode", 32'(alu_opcode), 0);
    chk("arst_out_result", 32'(out_result), 0);
    chk("arst_out_divz", 32'(out_divz), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    chk("post_rst_no_result", 32'(out_valid), 0);

    send(4'b0000, 20'd1, 20'd1, 4'd12);
    push(20'd2, 1'b0, 1'b0, 4'd12);
    wait_out("post_rst_add", 1, 1'b0);

    chk("sb_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
